// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues word reads to
// instruction memory and holds the fetched instruction for decode. Branch and
// jump redirects from decode select the next fetch address combinationally.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [15:0] imm16
);

    localparam logic [0:0] StFetch = 1'b0;
    localparam logic [0:0] StValid = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc;

    // The shift by two drops the top two offset bits; they carry no address information.
    logic unused_br_hi;
    assign unused_br_hi = ^br_offset[31:30];

    // Outputs derived directly from the held instruction and its address
    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        imm16       = instr_q[15:0];
        instr       = instr_q;
        pc          = pc_q;
        instr_valid = valid_q;
    end

    // Redirect selection; jump has priority over a taken branch
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (br_taken) begin
            next_pc = pc_plus4 + {br_offset[29:0], 2'b00};
        end
    end

    // Request generation and next-state for the two-state fetch FSM
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        imem_req   = 1'b0;
        imem_addr  = fetch_pc_q;
        case (state_q)
            StFetch: begin
                imem_req  = 1'b1;
                imem_addr = fetch_pc_q;
                if (imem_ready) begin
                    instr_d    = imem_rdata;
                    pc_d       = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    valid_d    = 1'b1;
                    state_d    = StValid;
                end
            end
            StValid: begin
                imem_addr = next_pc;
                // A stalled decode freezes everything, redirects included.
                if (!stall) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        instr_d    = imem_rdata;
                        pc_d       = next_pc;
                        fetch_pc_d = next_pc + 32'd4;
                    end else begin
                        fetch_pc_d = next_pc;
                        valid_d    = 1'b0;
                        state_d    = StFetch;
                    end
                end
            end
            default: state_d = StFetch;
        endcase
        if (!rst_n) begin
            imem_req = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            instr_q    <= 32'd0;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the datapath. It owns the program counter and issues word reads to instruction memory over a request/ready handshake. It holds the fetched instruction for decode, and drives `imm16` directly into the 16→32 sign extender. Branch and jump redirects come back from decode, including the sign-extended branch offset that the extender produces, and the unit computes the next PC from them.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  32  byte address of the requested word
- `imem_ready`  in  1  memory has valid `imem_rdata` this cycle; ignored when `imem_req`=0
- `imem_rdata`  in  32  instruction word
- `stall`  in  1  decode cannot accept; hold the current instruction
- `br_taken`  in  1  taken branch for the instruction on `instr`
- `br_offset`  in  32  sign-extended word offset from the sign extender
- `jump`  in  1  J-type redirect for the instruction on `instr`
- `jump_target`  in  26  instr[25:0] of the jump
- `instr`  out  32  held instruction (registered)
- `instr_valid`  out  1  `instr` is valid
- `pc`  out  32  address of `instr`
- `pc_plus4`  out  32  `pc` + 4
- `imm16`  out  16  `instr[15:0]`, wired to the sign extender input

## Operation
- Two-state FSM with states FETCH and VALID.
- Internal registers:
  - `fetch_pc`, the next address to request.
  - `instr`, `pc`, `instr_valid`.
- Next-PC selection `next_pc` is combinational and evaluated only in VALID:
  - If `jump`=1: `{pc_plus4[31:28], jump_target, 2'b00}`. Jump wins when `br_taken` is also 1.
  - Else if `br_taken`=1: `pc_plus4 + {br_offset[29:0], 2'b00}`.
  - Otherwise: `pc_plus4`.
- Arithmetic rules:
  - All addition is modulo 2^32, so wrap-around from 32'hFFFF_FFFC to 0 is silent.
  - br_offset[31:30] is discarded by the shift.
- FETCH state:
  - `imem_req`=1 and `imem_addr`=`fetch_pc`.
  - On an edge with `imem_ready`=1: `instr`←`imem_rdata`, `pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4, `instr_valid`←1, and the FSM goes to VALID.
  - Otherwise all registers hold.
- VALID state with `stall`=1:
  - `imem_req`=0.
  - Every register holds.
  - `br_taken` and `jump` are ignored.
- VALID state with `stall`=0:
  - The current instruction is consumed at this edge.
  - `imem_req`=1 and `imem_addr`=`next_pc`.
  - If `imem_ready`=1: load the new instruction (`pc`←`next_pc`, `fetch_pc`←`next_pc`+4) and stay in VALID.
  - Otherwise: `fetch_pc`←`next_pc`, `instr_valid`←0, and the FSM goes to FETCH.
- `br_taken` and `jump` are sampled only in VALID with `stall`=0. In any other case they have no effect.
- `imem_rdata` is never sampled unless `imem_req`=1 and `imem_ready`=1 on the same edge.

## Timing
- Reset applies on any rising edge with `rst_n`=0, including in the middle of a wait or a stall. It sets:
  - state FETCH
  - `fetch_pc`=`RESET_PC`
  - `instr`=0, `instr_valid`=0
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4
  - `imm16`=0
- `imem_req` is forced to 0 while `rst_n`=0.
- A response arriving in the same cycle as reset is discarded.
- Fetch latency: the instruction appears on `instr`, with `instr_valid`=1, in the cycle after the edge where `imem_ready`=1.
- With zero-wait memory and no stall, one instruction is accepted per cycle, back-to-back.
- Each memory wait cycle inserts one `instr_valid`=0 bubble. A redirect therefore costs no extra cycle beyond memory latency.
- `imem_addr` in VALID depends combinationally on `br_taken`, `jump`, `br_offset` and `jump_target`. These inputs must be stable before the clock edge.
- `pc_plus4` and `imm16` are combinational from registers, so they carry no extra latency.

## Test plan
- **Reset and first fetch.** `RESET_PC`=0. Release `rst_n`. `imem_ready`=1 in the first cycle with rdata=32'h2008_FFFF.
  - Required: `imem_addr`=0.
  - Next cycle: `instr`=2008FFFF, `pc`=0, `imm16`=FFFF, and the extender output reads FFFFFFFF.
- **Back-to-back and wait states.** Ready is 1 for 3 cycles, then 0 for 2 cycles, then 1.
  - Required: addresses 0, 4, 8, C.
  - `instr_valid` is low for exactly 2 cycles.
  - `pc` follows the addresses.
- **Stall.** `stall`=1 for 3 cycles while `pc`=8, with `br_taken`=1 asserted during the stall.
  - Required: `imem_req`=0, and `instr` and `pc` are unchanged.
  - The branch is ignored and the next address is C.
- **Branch arithmetic.**
  - At `pc`=32'h10 with `br_offset`=FFFF_FFFF: next address is 32'h10.
  - At `pc`=32'h10 with `br_offset`=0000_7FFF: next address is 32'h0002_0010.
  - At `pc`=FFFF_FFFC, sequential: next address wraps to 0.
- **Jump priority.** At `pc`=32'h4000_0000, `jump`=1 with `jump_target`=26'h000_0040, together with `br_taken`=1.
  - Required: next address is 32'h4000_0100.
- **Mid-operation reset.** Assert `rst_n`=0 for 1 cycle while in FETCH with `imem_ready`=1.
  - Required: the response is dropped, `instr_valid`=0 and `instr`=0.
  - The next request is to `RESET_PC`.
